// File: rtl/serializador_pkg.sv
// Shared constants and helpers for the parallel-in / serial-out transmitter.
package serializador_pkg;

   localparam logic OCIOSO     = 1'b0;
   localparam logic DESLOCANDO = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/contador_bits.sv
// Bit position counter for one frame; flags the last bit position.
module contador_bits
   import serializador_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic ultimo
);

   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] TOPO = CW'(WIDTH - 1);
   localparam logic [CW-1:0] UM   = CW'(1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + UM;
      end
   end

   assign ultimo = (count == TOPO);

endmodule

// File: rtl/serializador_paralelo.sv
// Parallel-in / serial-out shift register with load handshake and
// valid / last-bit flags; back-to-back frames need no idle cycle.
module serializador_paralelo
   import serializador_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             carga,
   input  logic [WIDTH-1:0] dado,
   input  logic             avanca,
   output logic             pronto,
   output logic             saida,
   output logic             valido,
   output logic             fim
);

   logic             estado;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] deslocado;
   logic             ultimo;
   logic             accept;
   logic             avancar;

   assign avancar = (estado == DESLOCANDO) && avanca;
   assign valido  = (estado == DESLOCANDO);
   assign fim     = valido && ultimo;
   assign pronto  = (estado == OCIOSO) || (fim && avanca);
   assign accept  = carga && pronto;

   contador_bits #(
      .WIDTH (WIDTH)
   ) u_contador (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept || (avancar && ultimo)),
      .enable (avancar && !ultimo),
      .ultimo (ultimo)
   );

   // The output end of the register is the bit currently on saida.
   generate
      if (MSB_FIRST) begin : g_msb
         assign saida     = sr[WIDTH-1];
         assign deslocado = {sr[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign saida     = sr[0];
         assign deslocado = {1'b0, sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= OCIOSO;
         sr     <= '0;
      end else if (accept) begin
         estado <= DESLOCANDO;
         sr     <= dado;
      end else if (avancar) begin
         if (ultimo) begin
            estado <= OCIOSO;
            sr     <= '0;
         end else begin
            sr <= deslocado;
         end
      end
   end

endmodule
